// File: rtl/tjmono_direct_tx_emu_if.sv
// Hit-injection and direct-readout signals between the TJ-Monopix2 TX emulator and its driver.
interface tjmono_direct_tx_emu_if #(
   parameter int DATA_WIDTH = 27
);
   logic                  hit_write;
   logic [DATA_WIDTH-1:0] hit_data;
   logic                  freeze;
   logic                  read;
   logic                  token;
   logic                  data;
   logic                  fifo_full;
   logic [7:0]            ovf_cnt;
   logic [7:0]            err_cnt;
   logic                  busy;

   modport master (
      output hit_write, hit_data, freeze, read,
      input  token, data, fifo_full, ovf_cnt, err_cnt, busy
   );

   modport slave (
      input  hit_write, hit_data, freeze, read,
      output token, data, fifo_full, ovf_cnt, err_cnt, busy
   );
endinterface

// File: rtl/tjmono_direct_tx_emu.sv
// Chip-side emulator of the TJ-Monopix2 direct readout: buffers hits, raises TOKEN,
// and serialises one word MSB-first per READ while FREEZE is held.
module tjmono_direct_tx_emu #(
   parameter int DATA_WIDTH = 27,
   parameter int DEPTH_LOG2 = 4
) (
   input logic                   clk_i,
   input logic                   rst_i,
   tjmono_direct_tx_emu_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, FROZEN, LOAD, SHIFT} state_e;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]     count_q;
   logic [DEPTH_LOG2:0]     frozen_q, frozen_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]           bitcnt_q, bitcnt_d;
   logic [7:0]              ovf_q, err_q;
   logic                    full, push, pop, err_inc;

   assign full = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign pop  = (state_q == LOAD);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push = bus.hit_write && (!full || pop);

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= bus.hit_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.hit_write && !push && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         frozen_q <= '0;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         frozen_q <= frozen_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      frozen_d = frozen_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      err_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            // Snapshot excludes a push landing in the same cycle.
            if (bus.freeze) begin
               state_d  = FROZEN;
               frozen_d = count_q;
            end
            if (bus.read) err_inc = 1'b1;
         end
         FROZEN: begin
            if (!bus.freeze) begin
               state_d = IDLE;
            end else if (bus.read) begin
               if (frozen_q != '0) state_d = LOAD;
               else                err_inc = 1'b1;
            end
         end
         LOAD: begin
            shreg_d  = mem_q[rptr_q];
            frozen_d = frozen_q - 1'b1;
            bitcnt_d = CW'(DATA_WIDTH - 1);
            state_d  = SHIFT;
            if (bus.read) err_inc = 1'b1;
         end
         SHIFT: begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - 1'b1;
            if (bitcnt_q == '0) state_d = bus.freeze ? FROZEN : IDLE;
            if (bus.read) err_inc = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.token     = (state_q == IDLE) ? (count_q != '0) : (frozen_q != '0);
   assign bus.data      = (state_q == SHIFT) && shreg_q[DATA_WIDTH-1];
   assign bus.busy      = (state_q == LOAD) || (state_q == SHIFT);
   assign bus.fifo_full = full;
   assign bus.ovf_cnt   = ovf_q;
   assign bus.err_cnt   = err_q;
endmodule
